// File: rtl/pqc_seq_pkg.sv
// Shared types for the operand sequencer: FSM state encoding, instruction word layout
// and the default widths the sequencer and its decoder agree on.
package pqc_seq_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int CODE_W_DEF     = 8;
  localparam int OPCODE_W_DEF   = 4;
  localparam int PROG_DEPTH_DEF = 64;
  localparam int MEM_DELAY_DEF  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE_A,
    S_WAIT_A,
    S_ISSUE_B,
    S_WAIT_B,
    S_PRESENT,
    S_DONE
  } seq_state_e;

  // Opcode sits in the MSBs of the ROM word.
  typedef struct packed {
    logic [OPCODE_W_DEF-1:0] opcode;
    logic [CODE_W_DEF-1:0]   code_a;
    logic [CODE_W_DEF-1:0]   code_b;
  } instr_t;

endpackage

// File: rtl/mem_delay_counter.sv
// Down-counter that times a fixed-latency memory read: loaded with MEM_DELAY-1,
// it flags expiry in the cycle the read data may be sampled.
module mem_delay_counter #(
  parameter int MEM_DELAY = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (MEM_DELAY > 1) ? $clog2(MEM_DELAY) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_DELAY - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/operand_sequencer.sv
// Walks a program ROM, runs the operand decoder on both codes of each instruction and
// hands the resulting {opcode, A, B} triple downstream over valid/ready.
module operand_sequencer
  import pqc_seq_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_W_DEF,
  parameter int CODE_WIDTH   = CODE_W_DEF,
  parameter int OPCODE_WIDTH = OPCODE_W_DEF,
  parameter int PROG_DEPTH   = PROG_DEPTH_DEF,
  parameter int MEM_DELAY    = MEM_DELAY_DEF,
  localparam int PA_W        = $clog2(PROG_DEPTH),
  localparam int INSTR_W     = OPCODE_WIDTH + 2 * CODE_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [PA_W:0]           prog_len,
  output logic                    busy,
  output logic                    done,
  output logic [PA_W-1:0]         prog_addr,
  input  logic [INSTR_W-1:0]      prog_data,
  output logic                    decode_start,
  output logic [CODE_WIDTH-1:0]   inp_code,
  input  logic                    data_ready,
  input  logic [DATA_WIDTH-1:0]   out_value,
  output logic                    op_valid,
  input  logic                    op_ready,
  output logic [OPCODE_WIDTH-1:0] op_opcode,
  output logic [DATA_WIDTH-1:0]   op_a,
  output logic [DATA_WIDTH-1:0]   op_b
);

  seq_state_e state, state_nxt;

  logic [PA_W:0]           pc_q, len_q, pc_inc;
  logic [OPCODE_WIDTH-1:0] opcode_q;
  logic [CODE_WIDTH-1:0]   code_b_q;
  instr_t                  fetched;
  logic                    last, fetch_done, cnt_load, cnt_en;

  assign fetched  = instr_t'(prog_data);
  assign pc_inc   = pc_q + 1'b1;
  assign last     = (pc_inc == len_q);
  assign cnt_load = (state_nxt == S_FETCH) && (state != S_FETCH);
  assign cnt_en   = (state == S_FETCH);

  mem_delay_counter #(
    .MEM_DELAY (MEM_DELAY)
  ) u_fetch_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (cnt_load),
    .en      (cnt_en),
    .expired (fetch_done)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = (prog_len == '0) ? S_DONE : S_FETCH;
      S_FETCH:   if (fetch_done) state_nxt = S_ISSUE_A;
      S_ISSUE_A: state_nxt = S_WAIT_A;
      S_WAIT_A:  if (data_ready) state_nxt = S_ISSUE_B;
      S_ISSUE_B: state_nxt = S_WAIT_B;
      S_WAIT_B:  if (data_ready) state_nxt = S_PRESENT;
      S_PRESENT: if (op_ready) state_nxt = last ? S_DONE : S_FETCH;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so every output leaves a flop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      pc_q         <= '0;
      len_q        <= '0;
      opcode_q     <= '0;
      code_b_q     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      prog_addr    <= '0;
      decode_start <= 1'b0;
      inp_code     <= '0;
      op_valid     <= 1'b0;
      op_opcode    <= '0;
      op_a         <= '0;
      op_b         <= '0;
    end else begin
      state        <= state_nxt;
      busy         <= (state_nxt != S_IDLE);
      done         <= (state_nxt == S_DONE);
      decode_start <= (state_nxt == S_ISSUE_A) || (state_nxt == S_ISSUE_B);
      op_valid     <= (state_nxt == S_PRESENT);
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q     <= prog_len;
            pc_q      <= '0;
            prog_addr <= '0;
          end
        end
        S_FETCH: begin
          if (fetch_done) begin
            opcode_q <= fetched.opcode;
            code_b_q <= fetched.code_b;
            inp_code <= fetched.code_a;
          end
        end
        S_WAIT_A: begin
          if (data_ready) begin
            op_a     <= out_value;
            inp_code <= code_b_q;
          end
        end
        S_WAIT_B: begin
          if (data_ready) begin
            op_b      <= out_value;
            op_opcode <= opcode_q;
          end
        end
        S_PRESENT: begin
          // The address is left on the final instruction so it never wraps.
          if (op_ready) begin
            pc_q <= pc_inc;
            if (!last) prog_addr <= pc_inc[PA_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: registered ROM and variable-latency decoder models, an
// expected-triple/expected-code scoreboard and directed scenarios with literal results.
module tb_operand_sequencer;

  localparam int DW    = 32;
  localparam int CW    = 8;
  localparam int OW    = 4;
  localparam int DEPTH = 64;
  localparam int PA_W  = 6;
  localparam int IW    = OW + 2 * CW;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            start = 1'b0;
  logic [PA_W:0]   prog_len = '0;
  logic            busy, done, decode_start, op_valid;
  logic [PA_W-1:0] prog_addr;
  logic [IW-1:0]   prog_data = '0;
  logic [CW-1:0]   inp_code;
  logic            data_ready = 1'b0;
  logic [DW-1:0]   out_value = '0;
  logic            op_ready = 1'b1;
  logic [OW-1:0]   op_opcode;
  logic [DW-1:0]   op_a, op_b;

  int checks = 0;
  int errors = 0;

  logic [IW-1:0]   rom [DEPTH];
  logic [67:0]     exp_q[$];
  logic [7:0]      exp_codes[$];
  logic [7:0]      ds_log[$];
  int              hs_idx = 0, hs_count = 0, done_count = 0, ds_count = 0;
  logic [67:0]     last_hs = '0;
  logic [PA_W-1:0] last_hs_addr = '0;
  int              dec_lat = 2;
  bit              dec_rand = 1'b0;
  bit              spur_dr = 1'b0;

  always #5 clock = ~clock;

  operand_sequencer dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .prog_len     (prog_len),
    .busy         (busy),
    .done         (done),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .decode_start (decode_start),
    .inp_code     (inp_code),
    .data_ready   (data_ready),
    .out_value    (out_value),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_opcode    (op_opcode),
    .op_a         (op_a),
    .op_b         (op_b)
  );

  // Synchronous ROM: one register stage, so data for an address settles within two edges.
  always @(posedge clock) prog_data <= rom[prog_addr];

  function automatic logic [31:0] dec_fn(input logic [7:0] c);
    return c[7] ? {16'hBBBB, 8'h00, c} : {16'hAAAA, 8'h00, c};
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_pass(input int len);
    logic [IW-1:0] w;
    exp_q.delete();
    exp_codes.delete();
    ds_log.delete();
    hs_idx = 0;
    for (int i = 0; i < len; i++) begin
      w = rom[i];
      exp_codes.push_back(w[15:8]);
      exp_codes.push_back(w[7:0]);
      exp_q.push_back({w[19:16], dec_fn(w[15:8]), dec_fn(w[7:0])});
    end
  endtask

  task automatic wait_done(input bit spur, inout int edges);
    bit got;
    got = 1'b0;
    while (!got && edges < 20000) begin
      @(posedge clock); #1;
      edges++;
      start = 1'b0;
      if (edges == 1) begin
        check("busy_rise", busy, 1);
        check("addr_start", prog_addr, 0);
      end
      if (done) got = 1'b1;
      else if (spur) begin
        start    = ($urandom_range(0, 7) == 0);
        prog_len = 7'd3;
        op_ready = ($urandom_range(0, 3) != 0);
      end
    end
    start    = 1'b0;
    op_ready = 1'b1;
    check("done_seen", got, 1);
  endtask

  task automatic end_checks();
    @(negedge clock); #1;
    check("exp_triples_left", exp_q.size(), 0);
    check("exp_codes_left", exp_codes.size(), 0);
    @(posedge clock); #1;
    check("busy_fall", {busy, done}, 0);
  endtask

  task automatic run_pass(input int len, input bit spur, output int edges);
    load_pass(len);
    prog_len = len[PA_W:0];
    start    = 1'b1;
    edges    = 0;
    wait_done(spur, edges);
    end_checks();
  endtask

  // Decoder model: answers each decode_start after a fixed or random latency.
  initial begin
    int         remaining;
    logic [7:0] code;
    bit         prev_v;
    remaining = 0;
    code      = '0;
    prev_v    = 1'b0;
    forever begin
      @(posedge clock); #1;
      data_ready = 1'b0;
      if (!reset_n) begin
        remaining = 0;
        prev_v    = 1'b0;
      end else begin
        if (decode_start) begin
          code      = inp_code;
          remaining = dec_rand ? int'($urandom_range(1, 5)) : dec_lat;
        end else if (remaining > 0) begin
          remaining--;
          if (remaining == 0) begin
            data_ready = 1'b1;
            out_value  = dec_fn(code);
          end
        end else if (spur_dr && prev_v && !op_valid && busy && !done &&
                     $urandom_range(0, 1) == 1) begin
          data_ready = 1'b1;
          out_value  = 32'hDEAD_BEEF;
        end
        prev_v = op_valid;
      end
    end
  end

  // Scoreboard / protocol monitor, sampled on the falling edge.
  initial begin
    bit              pv, pr, pd, prst;
    logic [67:0]     ptrip;
    logic [PA_W-1:0] paddr;
    logic [7:0]      pcode;
    pv = 1'b0; pr = 1'b0; pd = 1'b0; prst = 1'b0;
    ptrip = '0; paddr = '0; pcode = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        pv = 1'b0; pr = 1'b0; pd = 1'b0; prst = 1'b0;
      end else begin
        if (decode_start) begin
          ds_count++;
          ds_log.push_back(inp_code);
          check("ds_expected", exp_codes.size() != 0, 1);
          if (exp_codes.size() != 0) check("inp_code", inp_code, exp_codes.pop_front());
        end else if (prst && busy) begin
          check("inp_code_hold", inp_code, pcode);
        end
        if (op_valid && pv && !pr) begin
          check("hold_triple", {op_opcode, op_a, op_b}, ptrip);
          check("hold_addr", prog_addr, paddr);
        end
        if (op_valid && op_ready) begin
          hs_count++;
          last_hs      = {op_opcode, op_a, op_b};
          last_hs_addr = prog_addr;
          check("hs_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("triple", {op_opcode, op_a, op_b}, exp_q.pop_front());
          check("hs_addr", prog_addr, hs_idx[PA_W-1:0]);
          hs_idx++;
        end
        if (done) begin
          done_count++;
          check("done_width", pd, 0);
        end
        if (!busy) check("idle_quiet", {op_valid, decode_start, done}, 0);
        pv    = op_valid;
        pr    = op_ready;
        pd    = done;
        prst  = 1'b1;
        ptrip = {op_opcode, op_a, op_b};
        paddr = prog_addr;
        pcode = inp_code;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected summary before timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int edges, n, base_hs, base_done, base_ds;
    for (int i = 0; i < DEPTH; i++) rom[i] = '0;

    // Reset state
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_outputs", {busy, done, prog_addr, decode_start, inp_code, op_valid,
                          op_opcode, op_a, op_b}, 0);
    check("rst_busy", busy, 0);
    #2 reset_n = 1'b1;
    @(posedge clock); #1;

    // Single instruction
    rom[0]    = 20'h30581;
    dec_lat   = 2;
    op_ready  = 1'b1;
    base_hs   = hs_count;
    base_done = done_count;
    run_pass(1, 1'b0, edges);
    check("single_latency", edges, 10);
    check("single_hs_count", hs_count - base_hs, 1);
    check("single_triple", last_hs, {4'h3, 32'hAAAA0005, 32'hBBBB0081});
    check("single_done_count", done_count - base_done, 1);
    check("single_ds_n", ds_log.size(), 2);
    if (ds_log.size() == 2) begin
      check("single_code_a", ds_log[0], 8'h05);
      check("single_code_b", ds_log[1], 8'h81);
    end

    // Backpressure: five stalled cycles on the first triple
    rom[0]   = 20'hA129C;
    rom[1]   = 20'h53344;
    dec_lat  = 1;
    load_pass(2);
    op_ready = 1'b0;
    prog_len = 7'd2;
    start    = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    edges = 0;
    while (!op_valid && edges < 200) begin
      @(posedge clock); #1;
      edges++;
    end
    for (int k = 1; k <= 6; k++) begin
      if (k == 6) op_ready = 1'b1;
      check("bp_valid_held", op_valid, 1);
      check("bp_addr", prog_addr, 0);
      check("bp_triple", {op_opcode, op_a, op_b}, {4'hA, 32'hAAAA0012, 32'hBBBB009C});
      @(posedge clock); #1;
    end
    check("bp_valid_drop", op_valid, 0);
    edges = 100;
    wait_done(1'b0, edges);
    end_checks();
    check("bp_last_triple", last_hs, {4'h5, 32'hAAAA0033, 32'hAAAA0044});

    // Zero length
    base_ds   = ds_count;
    base_done = done_count;
    run_pass(0, 1'b0, edges);
    check("zero_latency", edges, 1);
    check("zero_ds", ds_count - base_ds, 0);
    check("zero_done_count", done_count - base_done, 1);

    // Reset while waiting on the B operand
    rom[0]  = 20'h10A0B;
    rom[1]  = 20'h28C8D;
    dec_lat = 5;
    load_pass(2);
    prog_len = 7'd2;
    start    = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    n = 0;
    edges = 0;
    while (n < 2 && edges < 200) begin
      if (decode_start) n++;
      if (n < 2) begin
        @(posedge clock); #1;
        edges++;
      end
    end
    check("rmp_reached_issue_b", n, 2);
    @(posedge clock); #1;
    #2 reset_n = 1'b0;
    #1;
    check("rmp_outputs_zero", {busy, done, prog_addr, decode_start, inp_code, op_valid,
                               op_opcode, op_a, op_b}, 0);
    load_pass(0);
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    @(posedge clock); #1;
    dec_lat = 2;
    base_hs = hs_count;
    run_pass(2, 1'b0, edges);
    check("rmp_rerun_hs", hs_count - base_hs, 2);
    check("rmp_rerun_last", last_hs, {4'h2, 32'hBBBB008C, 32'hBBBB008D});

    // Full program with random decoder latency and spurious start / data_ready
    for (int i = 0; i < DEPTH; i++) rom[i] = IW'($urandom);
    dec_rand  = 1'b1;
    spur_dr   = 1'b1;
    base_hs   = hs_count;
    base_done = done_count;
    run_pass(DEPTH, 1'b1, edges);
    check("full_hs_count", hs_count - base_hs, 64);
    check("full_last_addr", last_hs_addr, 6'd63);
    check("full_done_count", done_count - base_done, 1);
    spur_dr  = 1'b0;
    dec_rand = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
